// File: rtl/ac_pkg.sv
// Shared types for the analog comparator controller.
// FSM states, interrupt modes and the edge/mode match helper.
package ac_pkg;

  typedef enum logic [1:0] {
    AC_OFF    = 2'd0,
    AC_SETTLE = 2'd1,
    AC_RUN    = 2'd2
  } ac_state_e;

  typedef enum logic [1:0] {
    AC_INT_TOGGLE = 2'b00,
    AC_INT_NONE   = 2'b01,
    AC_INT_FALL   = 2'b10,
    AC_INT_RISE   = 2'b11
  } ac_intmode_e;

  // nv is the new filtered level; caller guarantees it differs from the old one
  function automatic logic irq_hit(
    input ac_intmode_e m,
    input logic        nv
  );
    logic hit;
    hit = 1'b0;
    unique case (m)
      AC_INT_TOGGLE: hit = 1'b1;
      AC_INT_NONE:   hit = 1'b0;
      AC_INT_FALL:   hit = ~nv;
      AC_INT_RISE:   hit = nv;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ac_filt.sv
// Two-flop synchroniser plus sample history for acout.
// Flags a window of FILT_LEN identical synchronised samples.
module ac_filt
  import ac_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic acout,
  output logic agree,
  output logic agree_val
);

  logic                sync1;
  logic                sync2;
  logic [FILT_LEN-2:0] hist;
  logic [FILT_LEN-1:0] win;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= '0;
    end else begin
      sync1   <= acout;
      sync2   <= sync1;
      hist[0] <= sync2;
      for (int i = 1; i < FILT_LEN - 1; i++) begin
        hist[i] <= hist[i-1];
      end
    end
  end

  assign win       = {hist, sync2};
  assign agree     = (&win) | ~(|win);
  assign agree_val = sync2;

endmodule

// File: rtl/ac_ctrl.sv
// Analog comparator sequencer: power-up, settle, filtered state
// and sticky edge interrupt.
module ac_ctrl
  import ac_pkg::*;
#(
  parameter int SETTLE_W = 8,
  parameter int FILT_LEN = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SETTLE_W-1:0] settle_cyc,
  input  logic [1:0]          intmode,
  input  logic                intclr,
  input  logic                acout,
  output logic                acenable,
  output logic                ready,
  output logic                acstate,
  output logic                acirq
);

  ac_state_e           state;
  ac_intmode_e         mode;
  logic [SETTLE_W-1:0] cnt;
  logic                valid;
  logic                agree;
  logic                agree_val;

  assign mode = ac_intmode_e'(intmode);

  ac_filt #(
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .clk       (clk),
    .rst       (rst),
    .acout     (acout),
    .agree     (agree),
    .agree_val (agree_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= AC_OFF;
      cnt      <= '0;
      valid    <= 1'b0;
      acenable <= 1'b0;
      ready    <= 1'b0;
      acstate  <= 1'b0;
      acirq    <= 1'b0;
    end else begin
      acirq <= acirq & ~intclr;
      if (!en) begin
        state    <= AC_OFF;
        acenable <= 1'b0;
        ready    <= 1'b0;
        acstate  <= 1'b0;
        valid    <= 1'b0;
      end else begin
        unique case (state)
          AC_OFF: begin
            state    <= AC_SETTLE;
            acenable <= 1'b1;
            cnt      <= settle_cyc;
          end
          AC_SETTLE: begin
            if (cnt == '0) begin
              state <= AC_RUN;
              ready <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          AC_RUN: begin
            // first qualified window only loads; later ones detect edges
            if (agree) begin
              if (!valid) begin
                acstate <= agree_val;
                valid   <= 1'b1;
              end else if (agree_val != acstate) begin
                acstate <= agree_val;
                if (irq_hit(mode, agree_val)) acirq <= 1'b1;
              end
            end
          end
          default: state <= AC_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ac_ctrl.sv
// Bench for ac_ctrl: directed scenarios plus random stimulus,
// every cycle compared to a sample-history reference model.
module tb_ac_ctrl;

  localparam int SW = 8;
  localparam int FL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [SW-1:0] settle_cyc;
  logic [1:0]    intmode;
  logic          intclr;
  logic          acout;
  logic          acenable;
  logic          ready;
  logic          acstate;
  logic          acirq;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  ac_ctrl #(
    .SETTLE_W (SW),
    .FILT_LEN (FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .settle_cyc (settle_cyc),
    .intmode    (intmode),
    .intclr     (intclr),
    .acout      (acout),
    .acenable   (acenable),
    .ready      (ready),
    .acstate    (acstate),
    .acirq      (acirq)
  );

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: q[0] is the acout sample of the previous edge,
  // q[1..FL] are the samples that form the filter window now.
  bit m_acen, m_ready, m_state, m_valid, m_irq;
  int m_left;
  bit q [0:FL];

  always @(posedge clk) begin : model
    bit ag, v, nirq;
    v  = q[1];
    ag = 1'b1;
    for (int i = 2; i <= FL; i++) if (q[i] != q[1]) ag = 1'b0;
    if (rst) begin
      m_acen = 0; m_ready = 0; m_state = 0; m_valid = 0; m_irq = 0;
      m_left = 0;
      for (int i = 0; i <= FL; i++) q[i] = 1'b0;
    end else begin
      nirq = m_irq && !intclr;
      if (!en) begin
        m_acen = 0; m_ready = 0; m_state = 0; m_valid = 0;
      end else if (!m_acen) begin
        m_acen = 1;
        m_left = int'(settle_cyc) + 1;
      end else if (!m_ready) begin
        m_left--;
        if (m_left == 0) m_ready = 1;
      end else if (ag) begin
        if (!m_valid) begin
          m_state = v;
          m_valid = 1;
        end else if (v != m_state) begin
          m_state = v;
          if (intmode == 2'b00) nirq = 1;
          if (intmode == 2'b10 && v == 1'b0) nirq = 1;
          if (intmode == 2'b11 && v == 1'b1) nirq = 1;
        end
      end
      m_irq = nirq;
      for (int i = FL; i >= 1; i--) q[i] = q[i-1];
      q[0] = acout;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("acenable", {7'd0, acenable}, {7'd0, m_acen});
      check("ready",    {7'd0, ready},    {7'd0, m_ready});
      check("acstate",  {7'd0, acstate},  {7'd0, m_state});
      check("acirq",    {7'd0, acirq},    {7'd0, m_irq});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 20) begin
      cyc(1);
      n++;
    end
  endtask

  initial begin
    int n;
    int run;
    rst = 1; en = 0; intclr = 0; acout = 0;
    settle_cyc = '0; intmode = 2'b00;
    cyc(2);
    chk_on = 1'b1;
    check("reset_outs", {4'd0, acenable, ready, acstate, acirq}, 8'd0);

    // power-up with settle 5, acout high through settle
    rst = 0; en = 1; settle_cyc = 8'd5; acout = 1;
    cyc(1);
    check("pwr_acen", {7'd0, acenable}, 8'd1);
    wait_ready(n);
    check("pwr_ready_edges", n[7:0], 8'd6);
    check("pwr_irq", {7'd0, acirq}, 8'd0);
    cyc(4);
    check("first_load_state", {7'd0, acstate}, 8'd1);
    check("first_load_irq", {7'd0, acirq}, 8'd0);

    // rising edge with rise mode, exact latency
    intmode = 2'b01; acout = 0;
    cyc(6);
    check("pre_rise_state", {7'd0, acstate}, 8'd0);
    intmode = 2'b11; acout = 1;
    cyc(4);
    check("rise_k3_state", {7'd0, acstate}, 8'd0);
    cyc(1);
    check("rise_state", {7'd0, acstate}, 8'd1);
    check("rise_irq", {7'd0, acirq}, 8'd1);

    // same rising step in fall mode
    intclr = 1; intmode = 2'b01; acout = 0;
    cyc(1);
    intclr = 0;
    cyc(6);
    intmode = 2'b10; acout = 1;
    cyc(6);
    check("fallmode_state", {7'd0, acstate}, 8'd1);
    check("fallmode_irq", {7'd0, acirq}, 8'd0);

    // glitches of 2 and 1 cycles rejected
    intmode = 2'b00;
    acout = 0; cyc(2); acout = 1; cyc(6);
    acout = 0; cyc(1); acout = 1; cyc(6);
    check("glitch_state", {7'd0, acstate}, 8'd1);
    check("glitch_irq", {7'd0, acirq}, 8'd0);
    acout = 0; cyc(3); acout = 1; cyc(8);
    check("pulse3_irq", {7'd0, acirq}, 8'd1);

    // clear racing a set
    intclr = 1; cyc(1); intclr = 0;
    check("clr_lone", {7'd0, acirq}, 8'd0);
    acout = 0;
    cyc(4);
    intclr = 1;
    cyc(1);
    intclr = 0;
    check("clr_race_irq", {7'd0, acirq}, 8'd1);
    check("clr_race_state", {7'd0, acstate}, 8'd0);
    intclr = 1; cyc(1); intclr = 0;
    check("clr_after", {7'd0, acirq}, 8'd0);

    // disable mid-settle, then re-enable with full reload
    en = 0; cyc(1);
    en = 1; settle_cyc = 8'd5;
    cyc(4);
    en = 0;
    cyc(1);
    check("dis_acen", {7'd0, acenable}, 8'd0);
    check("dis_ready", {7'd0, ready}, 8'd0);
    en = 1;
    cyc(1);
    settle_cyc = 8'd1;
    wait_ready(n);
    check("reen_ready_edges", n[7:0], 8'd6);

    // reset in RUN with a pending interrupt
    cyc(5);
    acout = 1;
    cyc(6);
    check("pre_rst_irq", {7'd0, acirq}, 8'd1);
    rst = 1;
    cyc(1);
    rst = 0;
    check("rst_run_outs", {4'd0, acenable, ready, acstate, acirq}, 8'd0);

    // random phase
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      en  = ($urandom_range(0, 149) != 0);
      settle_cyc = 8'($urandom_range(0, 7));
      intclr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) intmode = 2'($urandom_range(0, 3));
      if (run == 0) begin
        acout = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 6);
      end
      run--;
      cyc(1);
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
